// File: rtl/kernel_shell_pkg.sv
// Shared definitions for the kernel_shell host-memory shell: FSM state
// encoding, error-bit positions and the default kernel watchdog limit.
package kernel_shell_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READ,
    ST_RUN,
    ST_WAIT_WRITE,
    ST_FINISH
  } state_e;

  // Positions inside the 2-bit err output.
  localparam int ERR_CLAMP   = 0;
  localparam int ERR_TIMEOUT = 1;

  localparam int TIMEOUT_CYC_DEFAULT = 65535;

endpackage

// File: rtl/shell_dpram.sv
// Local DEPTH x DATA_WID true dual-port buffer shared by the shell FSM and
// the kernel. Both ports read and write; reads are registered (1 cycle),
// a read of an address written in the same cycle returns the old data, and
// on a same-address double write port 1 wins. Memory contents are never
// reset; only the read registers are, so q0/q1 drop to 0 with reset.
module shell_dpram #(
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce0,
  input  logic                we0,
  input  logic [ADDR_WID-1:0] addr0,
  input  logic [DATA_WID-1:0] d0,
  output logic [DATA_WID-1:0] q0,
  input  logic                ce1,
  input  logic                we1,
  input  logic [ADDR_WID-1:0] addr1,
  input  logic [DATA_WID-1:0] d1,
  output logic [DATA_WID-1:0] q1
);

  localparam int DEPTH = 2 ** ADDR_WID;

  logic [DATA_WID-1:0] mem [DEPTH];
  logic [DATA_WID-1:0] q0_q, q1_q;

  // Array writes; port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (ce0 && we0) mem[addr0] <= d0;
    if (ce1 && we1) mem[addr1] <= d1;
  end

  // Registered reads; each output holds while its port is not reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0_q <= '0;
      q1_q <= '0;
    end else begin
      if (ce0 && !we0) q0_q <= mem[addr0];
      if (ce1 && !we1) q1_q <= mem[addr1];
    end
  end

  assign q0 = q0_q;
  assign q1 = q1_q;

endmodule

// File: rtl/kernel_shell.sv
// kernel_shell: host-memory shell around an HLS kernel. A start pulse
// burst-reads num_read words into the local buffer, launches the kernel with
// the buffer on two memory ports, latches its return value on kernel_done,
// bursts num_write words back and pulses done. Counts clamp to the buffer
// depth (err[0]).
// Optional feature: define KERNEL_TIMEOUT_EN to build a RUN-state watchdog
// that aborts after TIMEOUT_CYC cycles with err[1] and an all-ones result.
module kernel_shell
  import kernel_shell_pkg::*;
#(
  parameter int DATA_WID    = 32,
  parameter int ADDR_WID    = 5,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         num_read,
  input  logic [63:0]         num_write,
  input  logic [63:0]         stride,
  input  logic                read_ready,
  input  logic [DATA_WID-1:0] read_data,
  input  logic                write_ready,
  output logic                read_enable,
  output logic                write_enable,
  output logic                finish_read,
  output logic                finish_write,
  output logic [63:0]         read_addr,
  output logic [63:0]         write_addr,
  output logic [63:0]         read_size_output,
  output logic [63:0]         write_size,
  output logic [DATA_WID-1:0] write_data,
  output logic                kernel_start,
  input  logic                kernel_done,
  input  logic [DATA_WID-1:0] kernel_ret,
  input  logic                ce0,
  input  logic                we0,
  input  logic                ce1,
  input  logic                we1,
  input  logic [ADDR_WID-1:0] addr0,
  input  logic [ADDR_WID-1:0] addr1,
  input  logic [DATA_WID-1:0] d0,
  input  logic [DATA_WID-1:0] d1,
  output logic [DATA_WID-1:0] q0,
  output logic [DATA_WID-1:0] q1,
  output logic [DATA_WID-1:0] returnvalue,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err
);

  // Counters carry one extra bit so a full-depth count is representable.
  localparam logic [ADDR_WID:0] CNT_DEPTH = {1'b1, {ADDR_WID{1'b0}}};
  localparam logic [ADDR_WID:0] CNT_ONE   = {{ADDR_WID{1'b0}}, 1'b1};
  localparam logic [63:0]       DEPTH64   = 64'(CNT_DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_WID:0]   nr_q, nr_d, nw_q, nw_d;
  logic [ADDR_WID:0]   rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [63:0]         stride_q, stride_d;
  logic [63:0]         rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic                fin_rd_q, fin_rd_d, fin_wr_q, fin_wr_d;
  logic                kstart_q, kstart_d, done_q, done_d;
  logic [DATA_WID-1:0] ret_q, ret_d;
  logic [1:0]          err_q, err_d;

  logic [ADDR_WID:0]   nr_clamp, nw_clamp;
  logic                over_cnt;
  logic [ADDR_WID:0]   rcnt_nx, wcnt_nx;
  logic                run_end;

  // Buffer port muxing between the FSM and the kernel.
  logic                m_ce0, m_we0, m_ce1, m_we1;
  logic [ADDR_WID-1:0] m_addr0, m_addr1;
  logic [DATA_WID-1:0] m_d0, m_d1, m_q0, m_q1;

`ifdef KERNEL_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

  assign nr_clamp = (num_read  > DEPTH64) ? CNT_DEPTH : num_read[ADDR_WID:0];
  assign nw_clamp = (num_write > DEPTH64) ? CNT_DEPTH : num_write[ADDR_WID:0];
  assign over_cnt = (num_read > DEPTH64) || (num_write > DEPTH64);
  assign rcnt_nx  = rcnt_q + CNT_ONE;
  assign wcnt_nx  = wcnt_q + CNT_ONE;

  shell_dpram #(
    .DATA_WID (DATA_WID),
    .ADDR_WID (ADDR_WID)
  ) u_buf (
    .clk   (clk),
    .rst_n (reset),
    .ce0   (m_ce0),
    .we0   (m_we0),
    .addr0 (m_addr0),
    .d0    (m_d0),
    .q0    (m_q0),
    .ce1   (m_ce1),
    .we1   (m_we1),
    .addr1 (m_addr1),
    .d1    (m_d1),
    .q1    (m_q1)
  );

  // Next-state, burst bookkeeping and buffer-port arbitration.
  always_comb begin
    state_d   = state_q;
    nr_d      = nr_q;
    nw_d      = nw_q;
    rcnt_d    = rcnt_q;
    wcnt_d    = wcnt_q;
    stride_d  = stride_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    fin_rd_d  = 1'b0;
    fin_wr_d  = 1'b0;
    kstart_d  = 1'b0;
    done_d    = 1'b0;
    ret_d     = ret_q;
    err_d     = err_q;
    run_end   = 1'b0;
    m_ce0     = 1'b0;
    m_we0     = 1'b0;
    m_addr0   = '0;
    m_d0      = '0;
    m_ce1     = 1'b0;
    m_we1     = 1'b0;
    m_addr1   = '0;
    m_d1      = '0;
`ifdef KERNEL_TIMEOUT_EN
    tmo_d     = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nr_d            = nr_clamp;
          nw_d            = nw_clamp;
          stride_d        = stride;
          rcnt_d          = '0;
          wcnt_d          = '0;
          err_d           = '0;
          err_d[ERR_CLAMP] = over_cnt;
          if (nr_clamp == '0) begin
            kstart_d = 1'b1;
            state_d  = ST_RUN;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = read_base;
            state_d   = ST_WAIT_READ;
          end
        end
      end

      ST_WAIT_READ: begin
        if (read_ready) begin
          m_ce0   = 1'b1;
          m_we0   = 1'b1;
          m_addr0 = rcnt_q[ADDR_WID-1:0];
          m_d0    = read_data;
          if (rcnt_nx == nr_q) begin
            rd_en_d  = 1'b0;
            kstart_d = 1'b1;
            state_d  = ST_RUN;
          end else begin
            rcnt_d    = rcnt_nx;
            rd_addr_d = rd_addr_q + stride_q;
            fin_rd_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        m_ce0   = ce0;
        m_we0   = we0;
        m_addr0 = addr0;
        m_d0    = d0;
        m_ce1   = ce1;
        m_we1   = we1;
        m_addr1 = addr1;
        m_d1    = d1;
        if (kernel_done) begin
          run_end = 1'b1;
          ret_d   = kernel_ret;
        end
`ifdef KERNEL_TIMEOUT_EN
        tmo_d = tmo_q + 32'd1;
        if (!kernel_done && (tmo_q == TMO_LAST)) begin
          run_end            = 1'b1;
          ret_d              = '1;
          err_d[ERR_TIMEOUT] = 1'b1;
        end
`endif
        if (run_end) begin
          if (nw_q == '0) begin
            state_d = ST_FINISH;
          end else begin
            // Steal port 0 on the hand-back cycle to prefetch buf[0].
            m_ce0     = 1'b1;
            m_we0     = 1'b0;
            m_addr0   = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = write_base;
            wcnt_d    = '0;
            state_d   = ST_WAIT_WRITE;
          end
        end
      end

      ST_WAIT_WRITE: begin
        if (write_ready) begin
          if (wcnt_nx == nw_q) begin
            wr_en_d = 1'b0;
            state_d = ST_FINISH;
          end else begin
            // Prefetch the next word so it is on write_data next cycle.
            m_ce0     = 1'b1;
            m_we0     = 1'b0;
            m_addr0   = wcnt_nx[ADDR_WID-1:0];
            wcnt_d    = wcnt_nx;
            wr_addr_d = wr_addr_q + stride_q;
            fin_wr_d  = 1'b1;
          end
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset forces every output low at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      nr_q      <= '0;
      nw_q      <= '0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      stride_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      fin_rd_q  <= 1'b0;
      fin_wr_q  <= 1'b0;
      kstart_q  <= 1'b0;
      done_q    <= 1'b0;
      ret_q     <= '0;
      err_q     <= '0;
`ifdef KERNEL_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      nr_q      <= nr_d;
      nw_q      <= nw_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      stride_q  <= stride_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      fin_rd_q  <= fin_rd_d;
      fin_wr_q  <= fin_wr_d;
      kstart_q  <= kstart_d;
      done_q    <= done_d;
      ret_q     <= ret_d;
      err_q     <= err_d;
`ifdef KERNEL_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign read_enable      = rd_en_q;
  assign write_enable     = wr_en_q;
  assign finish_read      = fin_rd_q;
  assign finish_write     = fin_wr_q;
  assign read_addr        = rd_addr_q;
  assign write_addr       = wr_addr_q;
  assign read_size_output = rd_en_q ? stride_q : '0;
  assign write_size       = wr_en_q ? stride_q : '0;
  assign write_data       = wr_en_q ? m_q0 : '0;
  assign kernel_start     = kstart_q;
  assign q0               = m_q0;
  assign q1               = m_q1;
  assign returnvalue      = ret_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_kernel_shell.sv
// Scoreboard bench for kernel_shell: the stimulus thread pushes expected
// read addresses, write beats and done results into queues; monitors pop and
// compare whenever the DUT presents the corresponding event.
module tb_kernel_shell;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   read_base = '0, write_base = '0, num_read = '0, num_write = '0, stride = '0;
  logic          read_ready = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic          write_ready = 1'b0;
  logic          read_enable, write_enable, finish_read, finish_write;
  logic [63:0]   read_addr, write_addr, read_size_output, write_size;
  logic [DW-1:0] write_data;
  logic          kernel_start;
  logic          kernel_done = 1'b0;
  logic [DW-1:0] kernel_ret = '0;
  logic          ce0 = 1'b0, we0 = 1'b0, ce1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic [DW-1:0] q0, q1, returnvalue;
  logic          busy, done;
  logic [1:0]    err;

  kernel_shell #(
    .DATA_WID (DW),
    .ADDR_WID (AW)
`ifdef KERNEL_TIMEOUT_EN
    , .TIMEOUT_CYC (10)
`endif
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .read_base (read_base), .write_base (write_base),
    .num_read (num_read), .num_write (num_write), .stride (stride),
    .read_ready (read_ready), .read_data (read_data), .write_ready (write_ready),
    .read_enable (read_enable), .write_enable (write_enable),
    .finish_read (finish_read), .finish_write (finish_write),
    .read_addr (read_addr), .write_addr (write_addr),
    .read_size_output (read_size_output), .write_size (write_size),
    .write_data (write_data), .kernel_start (kernel_start),
    .kernel_done (kernel_done), .kernel_ret (kernel_ret),
    .ce0 (ce0), .we0 (we0), .ce1 (ce1), .we1 (we1),
    .addr0 (addr0), .addr1 (addr1), .d0 (d0), .d1 (d1),
    .q0 (q0), .q1 (q1), .returnvalue (returnvalue),
    .busy (busy), .done (done), .err (err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [DW-1:0] ret; logic [1:0] e; } dn_t;

  logic [63:0] exp_raddr[$];
  wr_t         exp_wr[$];
  dn_t         exp_dn[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int start_cyc, kdone_cyc, last_read_cyc, last_write_cyc, kstart_cyc, done_cyc;
  int ren_rise_cyc, wen_rise_cyc;
  int rd_words = 0, fr_cnt = 0, fw_cnt = 0;
  logic ren_prev = 1'b0, wen_prev = 1'b0;
  logic [63:0] cur_stride = '0;
  bit rd_toggle = 0, wr_toggle = 0, wr_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Host memory contents: a fixed pattern derived from the byte address.
  function automatic logic [DW-1:0] hw(input logic [63:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string msg);
    n_chk++;
    $display("FAIL %s", msg);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic sig_sel(input int w);
    case (w)
      0: return kernel_start;
      1: return done;
      default: return write_enable;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string name, input int budget);
    int n = 0;
    while (!sig_sel(w) && n < budget) begin
      step();
      n++;
    end
    chk({name, " seen"}, 64'(sig_sel(w)), 64'd1);
  endtask

  task automatic run_job(input logic [63:0] rb, wb, nr, nw, st);
    read_base = rb; write_base = wb; num_read = nr; num_write = nw;
    stride = st; cur_stride = st;
    start = 1'b1; start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic push_reads(input logic [63:0] rb, st, input int n);
    for (int i = 0; i < n; i++) exp_raddr.push_back(rb + 64'(i) * st);
  endtask

  task automatic push_write(input logic [63:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a; w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_done(input logic [DW-1:0] r, input logic [1:0] e);
    dn_t x;
    x.ret = r; x.e = e;
    exp_dn.push_back(x);
  endtask

  task automatic pulse_kdone(input logic [DW-1:0] r);
    kernel_ret = r; kernel_done = 1'b1; kdone_cyc = cyc;
    step();
    kernel_done = 1'b0;
  endtask

  // Host channel responder.
  initial forever begin
    @(posedge clk); #1;
    if (read_enable) begin
      read_ready = rd_toggle ? ~read_ready : 1'b1;
      read_data  = hw(read_addr);
    end else begin
      read_ready = 1'b0;
    end
    if (write_enable && !wr_hold) write_ready = wr_toggle ? ~write_ready : 1'b1;
    else write_ready = 1'b0;
  end

  // Monitors: pop and compare on every observed DUT event.
  always @(negedge clk) begin
    if (reset) begin
      if (read_enable && read_ready) begin
        rd_words++;
        last_read_cyc = cyc;
        if (exp_raddr.size() == 0) fail($sformatf("unexpected read at 0x%0h", read_addr));
        else chk("read_addr", read_addr, exp_raddr.pop_front());
        chk("read_size_output", read_size_output, cur_stride);
      end
      if (write_enable && write_ready) begin
        wr_t w;
        last_write_cyc = cyc;
        if (exp_wr.size() == 0) fail($sformatf("unexpected write at 0x%0h", write_addr));
        else begin
          w = exp_wr.pop_front();
          chk("write_addr", write_addr, w.a);
          chk("write_data", 64'(write_data), 64'(w.d));
        end
        chk("write_size", write_size, cur_stride);
      end
      if (done) begin
        dn_t x;
        done_cyc = cyc;
        chk("busy low at done", 64'(busy), 64'd0);
        if (exp_dn.size() == 0) fail("unexpected done pulse");
        else begin
          x = exp_dn.pop_front();
          chk("returnvalue", 64'(returnvalue), 64'(x.ret));
          chk("err", 64'(err), 64'(x.e));
        end
      end
      if (kernel_start) kstart_cyc = cyc;
      if (finish_read) fr_cnt++;
      if (finish_write) fw_cnt++;
      if (read_enable && !ren_prev) ren_rise_cyc = cyc;
      if (write_enable && !wen_prev) wen_rise_cyc = cyc;
    end
    ren_prev = read_enable;
    wen_prev = write_enable;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int fr0, fw0, rw0;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) step();
    chk("reset busy", 64'(busy), 0);
    chk("reset read_enable", 64'(read_enable), 0);
    chk("reset write_enable", 64'(write_enable), 0);
    chk("reset done", 64'(done), 0);
    chk("reset kernel_start", 64'(kernel_start), 0);
    chk("reset returnvalue", 64'(returnvalue), 0);
    chk("reset err", 64'(err), 0);
    chk("reset q0", 64'(q0), 0);
    reset = 1'b1;
    repeat (2) step();

    // Basic 4-in / 4-out job with an echoing kernel.
    push_reads(64'h100, 64'd4, 4);
    for (int i = 0; i < 4; i++) push_write(64'h200 + 64'(4 * i), hw(64'h100 + 64'(4 * i)));
    push_done(32'd7, 2'b00);
    fr0 = fr_cnt; fw0 = fw_cnt;
    run_job(64'h100, 64'h200, 64'd4, 64'd4, 64'd4);
    wait_sig(0, "t1 kernel_start", 200);
    for (int i = 0; i < 4; i++) begin
      ce0 = 1'b1; we0 = 1'b0; addr0 = AW'(i);
      step();
      ce0 = 1'b0;
      ce1 = 1'b1; we1 = 1'b1; addr1 = AW'(i); d1 = q0;
      step();
      ce1 = 1'b0; we1 = 1'b0;
    end
    pulse_kdone(32'd7);
    wait_sig(1, "t1 done", 200);
    step();
    chk("t1 start->read_enable", 64'(ren_rise_cyc - start_cyc), 1);
    chk("t1 last read->kernel_start", 64'(kstart_cyc - last_read_cyc), 1);
    chk("t1 kernel_done->write_enable", 64'(wen_rise_cyc - kdone_cyc), 1);
    chk("t1 last write->done", 64'(done_cyc - last_write_cyc), 2);
    chk("t1 finish_read pulses", 64'(fr_cnt - fr0), 3);
    chk("t1 finish_write pulses", 64'(fw_cnt - fw0), 3);
    repeat (2) step();

    // Oversized read count clamps to the depth; addresses wrap at 2^64.
    push_reads(64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 32);
    push_done(32'h55, 2'b01);
    rw0 = rd_words;
    run_job(64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'd40, 64'd0, 64'd8);
    wait_sig(0, "t2 kernel_start", 200);
    pulse_kdone(32'h55);
    wait_sig(1, "t2 done", 50);
    step();
    chk("t2 read count", 64'(rd_words - rw0), 32);
    repeat (2) step();

    // Throttled channels; kernel exercises collisions and read-old-data.
    rd_toggle = 1; wr_toggle = 1;
    push_reads(64'h1000, 64'd8, 4);
    push_write(64'h2000, 32'h1111_1111);
    push_write(64'h2008, 32'hBBBB_0000);
    push_write(64'h2010, 32'hCCCC_0000);
    push_write(64'h2018, hw(64'h1018));
    push_done(32'hDEAD, 2'b00);
    fr0 = fr_cnt; fw0 = fw_cnt;
    run_job(64'h1000, 64'h2000, 64'd4, 64'd4, 64'd8);
    wait_sig(0, "t3 kernel_start", 300);
    ce0 = 1'b1; we0 = 1'b1; addr0 = 5'd1; d0 = 32'hAAAA_0000;
    ce1 = 1'b1; we1 = 1'b1; addr1 = 5'd1; d1 = 32'hBBBB_0000;
    step();
    addr0 = 5'd0; d0 = 32'h1111_1111; ce1 = 1'b0; we1 = 1'b0;
    step();
    we0 = 1'b0; addr0 = 5'd2;
    ce1 = 1'b1; we1 = 1'b1; addr1 = 5'd2; d1 = 32'hCCCC_0000;
    step();
    chk("t3 read during write returns old", 64'(q0), 64'(hw(64'h1010)));
    ce0 = 1'b0; we1 = 1'b0; addr1 = 5'd0;
    step();
    chk("t3 q0 holds when idle", 64'(q0), 64'(hw(64'h1010)));
    chk("t3 q1 reads kernel write", 64'(q1), 64'h1111_1111);
    ce1 = 1'b0;
    pulse_kdone(32'hDEAD);
    wait_sig(1, "t3 done", 300);
    step();
    chk("t3 finish_read pulses", 64'(fr_cnt - fr0), 3);
    chk("t3 finish_write pulses", 64'(fw_cnt - fw0), 3);
    rd_toggle = 0; wr_toggle = 0;
    repeat (2) step();

    // Asynchronous reset in the middle of the write burst.
    wr_hold = 1;
    push_reads(64'h500, 64'd4, 1);
    run_job(64'h500, 64'h600, 64'd1, 64'd4, 64'd4);
    wait_sig(0, "t4 kernel_start", 50);
    pulse_kdone(32'h99);
    wait_sig(2, "t4 write_enable", 50);
    #2 reset = 1'b0;
    #1;
    chk("t4 write_enable after reset", 64'(write_enable), 0);
    chk("t4 busy after reset", 64'(busy), 0);
    chk("t4 write_addr after reset", write_addr, 0);
    chk("t4 write_size after reset", write_size, 0);
    chk("t4 returnvalue after reset", 64'(returnvalue), 0);
    step();
    wr_hold = 0;
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();

    // Clean job after reset.
    push_reads(64'h40, 64'd4, 2);
    push_write(64'h80, hw(64'h40));
    push_write(64'h84, hw(64'h44));
    push_done(32'h77, 2'b00);
    run_job(64'h40, 64'h80, 64'd2, 64'd2, 64'd4);
    wait_sig(0, "t5 kernel_start", 50);
    pulse_kdone(32'h77);
    wait_sig(1, "t5 done", 50);
    repeat (2) step();

    // Zero-length job: launch and completion latencies.
    push_done(32'h1234, 2'b00);
    rw0 = rd_words;
    run_job(64'h0, 64'h0, 64'd0, 64'd0, 64'd4);
    wait_sig(0, "t6 kernel_start", 10);
    step();
    pulse_kdone(32'h1234);
    wait_sig(1, "t6 done", 10);
    step();
    chk("t6 start->kernel_start", 64'(kstart_cyc - start_cyc), 1);
    chk("t6 kernel_done->done", 64'(done_cyc - kdone_cyc), 2);
    chk("t6 no reads", 64'(rd_words - rw0), 0);
    repeat (2) step();

`ifdef KERNEL_TIMEOUT_EN
    // Kernel never finishes: watchdog forces writeback with all-ones result.
    push_reads(64'h700, 64'd4, 1);
    push_write(64'h800, hw(64'h700));
    push_done('1, 2'b10);
    run_job(64'h700, 64'h800, 64'd1, 64'd1, 64'd4);
    wait_sig(1, "t7 timeout done", 100);
    repeat (2) step();
`endif

    chk("read queue drained", 64'(exp_raddr.size()), 0);
    chk("write queue drained", 64'(exp_wr.size()), 0);
    chk("done queue drained", 64'(exp_dn.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kernel_shell.md
# kernel_shell

Parametrised host-memory shell for an HLS-generated kernel. On a `start` pulse it burst-reads `num_read` words from host memory into a local dual-port buffer, then hands the buffer to the kernel through two ce/we/addr/d/q ports. When the kernel signals done it latches the kernel return value, bursts `num_write` words back to host memory and pulses `done`. It sits between the host read/write channel and the kernel and replaces the fixed 32×32 single-shot shell: data width and depth are generic, read and write counts are independent, the block is restartable, and count overflow is reported.

## Interface
Parameters:
- `DATA_WID`, 32, buffer and kernel data width.
- `ADDR_WID`, 5, buffer address width; `DEPTH = 2**ADDR_WID`.
- `TIMEOUT_CYC`, 65535, kernel watchdog limit in cycles; used only with `KERNEL_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `read_base`, `write_base` in 64: host byte base addresses.
- `num_read`, `num_write` in 64: word counts.
- `stride` in 64: address increment per word.
- `read_ready` in 1: host read data valid.
- `read_data` in `DATA_WID`: host read data.
- `write_ready` in 1: host write accepted.
- `read_enable`, `write_enable` out 1: channel request levels.
- `finish_read`, `finish_write` out 1: per-word acknowledge pulses.
- `read_addr`, `write_addr` out 64: current host addresses.
- `read_size_output`, `write_size` out 64: equal to `stride` for the duration of a burst; 0 otherwise.
- `write_data` out `DATA_WID`: write data.
- `kernel_start` out 1: one-cycle kernel launch.
- `kernel_done` in 1: kernel completion.
- `kernel_ret` in `DATA_WID`: kernel return value.
- `ce0`, `we0`, `ce1`, `we1` in 1: kernel buffer port controls.
- `addr0`, `addr1` in `ADDR_WID`: kernel buffer port addresses.
- `d0`, `d1` in `DATA_WID`: kernel write data.
- `q0`, `q1` out `DATA_WID`: kernel read data.
- `returnvalue` out `DATA_WID`: latched kernel result.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 2: bit0 = count clamped; bit1 = kernel timeout.

## Operation
- States: IDLE, WAIT_READ, RUN, WAIT_WRITE, FINISH.
- Counts are clamped to `DEPTH`. A count greater than `DEPTH` sets `err[0]`; `err` is held until the next accepted `start`.
- **IDLE.** On `start`:
  - Latch the clamped counts and clear `err`.
  - If the clamped `num_read` is 0, go directly to RUN with `kernel_start`=1.
  - Otherwise set `read_enable`=1 and `read_addr`=`read_base`, and go to WAIT_READ.
- **WAIT_READ.** On each cycle with `read_ready`=1:
  - Write `read_data` into `buf[rcnt]`.
  - Not the last word: `rcnt`++, `read_addr` += `stride`, and `finish_read`=1 for one cycle.
  - Last word: `read_enable`=0, `kernel_start`=1 for one cycle, go to RUN.
  - With `read_ready`=0, all state holds.
- **RUN.**
  - Each port: `ce`&`we` writes `d` into `buf[addr]`; `ce`&!`we` loads `q`<=`buf[addr]` (1-cycle read latency).
  - `q` holds its value when `ce`=0.
  - Both ports writing the same address in one cycle: port 1 wins.
  - Read and write to the same address in one cycle: the read returns the old data.
  - On `kernel_done`: `returnvalue`<=`kernel_ret`.
    - If the clamped `num_write` is 0, go to FINISH.
    - Otherwise set `write_enable`=1, `write_addr`=`write_base`, `write_data`=`buf[0]`, and go to WAIT_WRITE.
- **WAIT_WRITE.** On each cycle with `write_ready`=1:
  - Not the last word: `wcnt`++, `write_addr` += `stride`, `write_data`=`buf[wcnt+1]`, and `finish_write`=1 for one cycle.
  - Last word: `write_enable`=0, go to FINISH.
- **FINISH.** `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- `kernel_done` outside RUN is ignored.
- Address arithmetic is 64-bit and wraps modulo 2^64.
- Counters are `ADDR_WID`+1 bits wide so that a count of `DEPTH` fits.

## Timing
- Reset asserted: all outputs go to 0 immediately and the FSM goes to IDLE, including when reset arrives mid-burst. Buffer contents are not reset.
- `start` to `read_enable`: 1 cycle.
- One word per `read_ready` or `write_ready` cycle; back-to-back ready sustains one word per cycle.
- Last read word to `kernel_start`: 1 cycle.
- `kernel_done` to `write_enable`: 1 cycle.
- Last write acceptance to `done`: 2 cycles.
- `busy` is 0 only in IDLE, so `busy` falls in the same cycle `done` pulses.

## Configuration
- `KERNEL_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN.
  - If `kernel_done` has not arrived after `TIMEOUT_CYC` cycles, set `err[1]`, set `returnvalue` to all ones, and proceed exactly as on `kernel_done`.
- `KERNEL_TIMEOUT_EN` undefined:
  - No counter is built; RUN waits indefinitely.
  - `err[1]` is tied to 0.

## Structure
- Shared package `kernel_shell_pkg`: state enum, `err` bit indices, default `TIMEOUT_CYC`.
- One sub-module, `shell_dpram`: `DEPTH`×`DATA_WID`, two read/write ports, 1-cycle registered read, port 1 wins on a write collision.
- During the read burst the FSM drives port 0 of `shell_dpram`; during the write burst it reads through port 0. In RUN both ports are muxed to the kernel.

## Test plan
- `num_read`=`num_write`=4, `stride`=4, `read_base`=0x100, `write_base`=0x200, kernel echoes data, `ret`=7 -> read addresses 0x100/0x104/0x108/0x10C; writes to 0x200..0x20C carry the same 4 words; `returnvalue`=7; one `done` pulse; `err`=0.
- `num_read`=40 with `DEPTH`=32 -> exactly 32 reads; `err[0]`=1.
- `read_ready` toggled every other cycle -> no dropped or duplicated word; `finish_read` pulses exactly 3 times for 4 words.
- Reset deasserted→asserted while in WAIT_WRITE -> `write_enable`=0 and `busy`=0 asynchronously; a following `start` runs a clean job.
- `num_read`=0, `num_write`=0 -> `kernel_start` 1 cycle after `start`; `done` 2 cycles after `kernel_done`.
- With `KERNEL_TIMEOUT_EN` and `TIMEOUT_CYC`=10, kernel never done -> `err[1]`=1; `returnvalue`=all ones; writeback proceeds.
